fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// ============================================================================
//  Module   : fetch_stage
//  Brief    : Single-outstanding instruction fetch with redirect handling,
//             valid/ready hand-off to decode and immediate-format select.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_valid,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic [2:0]  out_imm_control
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] outpc_q, outpc_d;
   logic [31:0] instr_q, instr_d;
   logic [2:0]  imm_q, imm_d;

   logic [31:0] w_redirect_pc;
   logic [31:0] w_pc_inc;

   function automatic logic [2:0] imm_sel(input logic [6:0] opc);
      case (opc)
         7'b0010011, 7'b0000011, 7'b1100111: imm_sel = 3'b001;
         7'b0100011:                         imm_sel = 3'b010;
         7'b1100011:                         imm_sel = 3'b011;
         7'b0110111, 7'b0010111:             imm_sel = 3'b100;
         7'b1101111:                         imm_sel = 3'b101;
         default:                            imm_sel = 3'b000;
      endcase
   endfunction

   assign w_redirect_pc = {redirect_pc[31:2], 2'b00};
   assign w_pc_inc      = pc_q + 32'd4;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      outpc_d = outpc_q;
      instr_d = instr_q;
      imm_d   = imm_q;
      case (state_q)
         S_FETCH: begin
            if (redirect) begin
               pc_d = w_redirect_pc;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // A redirect always discards the response, whether it is here now or still in flight.
            if (redirect) begin
               pc_d    = w_redirect_pc;
               state_d = imem_valid ? S_FETCH : S_DRAIN;
            end else if (imem_valid) begin
               instr_d = imem_rdata;
               outpc_d = pc_q;
               imm_d   = imm_sel(imem_rdata[6:0]);
               valid_d = 1'b1;
               pc_d    = w_pc_inc;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_d    = w_redirect_pc;
               valid_d = 1'b0;
               state_d = S_FETCH;
            end else if (out_ready) begin
               valid_d = 1'b0;
               state_d = S_FETCH;
            end
         end
         S_DRAIN: begin
            if (redirect) begin
               pc_d = w_redirect_pc;
            end
            if (imem_valid) begin
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         outpc_q <= 32'd0;
         instr_q <= 32'd0;
         imm_q   <= 3'b000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         outpc_q <= outpc_d;
         instr_q <= instr_d;
         imm_q   <= imm_d;
      end
   end

   // Redirect suppresses the issue so the request always carries the final PC.
   assign imem_req        = !rst && (state_q == S_FETCH) && !redirect;
   assign imem_addr       = pc_q;
   assign out_valid       = valid_q;
   assign out_pc          = outpc_q;
   assign out_instr       = instr_q;
   assign out_imm_control = imm_q;

endmodule

`default_nettype wire
